// File: rtl/adc_calc_val_bank_if.sv
// Per-channel gain and offset AXI4-Stream bundle between the calibration bank
// and the FP conversion pipeline.
interface adc_calc_val_bank_if #(
   parameter int unsigned CH_NUM = 3,
   parameter int unsigned DW     = 32
);
   logic [CH_NUM*DW-1:0] gain_m_axis_tdata;
   logic [CH_NUM-1:0]    gain_m_axis_tvalid;
   logic [CH_NUM-1:0]    gain_m_axis_tready;
   logic [CH_NUM*DW-1:0] offset_m_axis_tdata;
   logic [CH_NUM-1:0]    offset_m_axis_tvalid;
   logic [CH_NUM-1:0]    offset_m_axis_tready;

   modport master (
      output gain_m_axis_tdata,
      output gain_m_axis_tvalid,
      input  gain_m_axis_tready,
      output offset_m_axis_tdata,
      output offset_m_axis_tvalid,
      input  offset_m_axis_tready
   );

   modport slave (
      input  gain_m_axis_tdata,
      input  gain_m_axis_tvalid,
      output gain_m_axis_tready,
      input  offset_m_axis_tdata,
      input  offset_m_axis_tvalid,
      output offset_m_axis_tready
   );
endinterface

// File: rtl/adc_calc_val_bank.sv
// Run-time programmable bank of per-channel ADC gain/offset constants with a
// shadow/active double buffer, streamed as constants (MODE 0) or one-shot beats (MODE 1).
module adc_calc_val_bank #(
   parameter int unsigned    CH_NUM     = 3,
   parameter int unsigned    DW         = 32,
   parameter logic [DW-1:0]  DEF_GAIN   = DW'(32'h35A0_0000),
   parameter logic [DW-1:0]  DEF_OFFSET = DW'(32'hC120_0000),
   parameter int unsigned    MODE       = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wr_en,
   input  logic [3:0]            i_wr_ch,
   input  logic                  i_wr_sel,
   input  logic [DW-1:0]         i_wr_data,
   input  logic                  i_apply,
   input  logic                  i_restore,
   adc_calc_val_bank_if.master   m_axis,
   output logic                  o_pending,
   output logic                  o_wr_err,
   output logic [15:0]           o_apply_cnt
);

   typedef logic [DW-1:0] word_t;

   // Index 0 = gain stream, index 1 = offset stream.
   word_t             shadow_q    [2][CH_NUM];
   word_t             shadow_d    [2][CH_NUM];
   word_t             data_q      [2][CH_NUM];
   word_t             data_d      [2][CH_NUM];
   word_t             hold_data_q [2][CH_NUM];
   word_t             hold_data_d [2][CH_NUM];
   logic [CH_NUM-1:0] valid_q [2];
   logic [CH_NUM-1:0] valid_d [2];
   logic [CH_NUM-1:0] hold_q  [2];
   logic [CH_NUM-1:0] hold_d  [2];
   logic [CH_NUM-1:0] ready   [2];

   logic        started_q;
   logic        pending_q, pending_d;
   logic        wr_err_q, wr_err_d;
   logic [15:0] cnt_q, cnt_d;

   logic ch_ok, wr_ok, commit;

   assign ready[0] = m_axis.gain_m_axis_tready;
   assign ready[1] = m_axis.offset_m_axis_tready;

   assign ch_ok  = ({1'b0, i_wr_ch} < 5'(CH_NUM));
   assign wr_ok  = i_wr_en & ch_ok & ~i_restore;
   assign commit = i_apply | i_restore;

   always_comb begin
      word_t def_val;
      word_t cval;
      logic  wr_hit;
      logic  hs;
      shadow_d    = shadow_q;
      data_d      = data_q;
      hold_data_d = hold_data_q;
      valid_d     = valid_q;
      hold_d      = hold_q;
      def_val     = '0;
      cval        = '0;
      wr_hit      = 1'b0;
      hs          = 1'b0;
      for (int s = 0; s < 2; s++) begin
         for (int unsigned c = 0; c < CH_NUM; c++) begin
            def_val = (s == 0) ? DEF_GAIN : DEF_OFFSET;
            wr_hit  = wr_ok && (i_wr_ch == 4'(c)) && (i_wr_sel == 1'(s));
            // Same-cycle write is bypassed into the committed value.
            if (i_restore) begin
               shadow_d[s][c] = def_val;
               cval           = def_val;
            end else if (wr_hit) begin
               shadow_d[s][c] = i_wr_data;
               cval           = i_wr_data;
            end else begin
               cval = shadow_q[s][c];
            end

            hs = valid_q[s][c] & ready[s][c];
            if (MODE == 0 || !started_q) begin
               valid_d[s][c] = 1'b1;
               if (commit) data_d[s][c] = cval;
            end else if (commit) begin
               if (!valid_q[s][c] || hs) begin
                  data_d[s][c]  = cval;
                  valid_d[s][c] = 1'b1;
                  hold_d[s][c]  = 1'b0;
               end else begin
                  // Stalled beat must stay stable; park the latest commit.
                  hold_d[s][c]      = 1'b1;
                  hold_data_d[s][c] = cval;
               end
            end else if (hs) begin
               if (hold_q[s][c]) begin
                  data_d[s][c] = hold_data_q[s][c];
                  hold_d[s][c] = 1'b0;
               end else begin
                  valid_d[s][c] = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      pending_d = pending_q;
      wr_err_d  = wr_err_q;
      cnt_d     = cnt_q;
      if (commit) begin
         pending_d = 1'b0;
      end else if (wr_ok) begin
         pending_d = 1'b1;
      end
      if (i_restore) begin
         wr_err_d = 1'b0;
      end else if (i_wr_en && !ch_ok) begin
         wr_err_d = 1'b1;
      end else if (i_apply) begin
         wr_err_d = 1'b0;
      end
      if (i_apply && !i_restore) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int unsigned c = 0; c < CH_NUM; c++) begin
            shadow_q[0][c]    <= DEF_GAIN;
            shadow_q[1][c]    <= DEF_OFFSET;
            data_q[0][c]      <= DEF_GAIN;
            data_q[1][c]      <= DEF_OFFSET;
            hold_data_q[0][c] <= DEF_GAIN;
            hold_data_q[1][c] <= DEF_OFFSET;
         end
         valid_q[0] <= '0;
         valid_q[1] <= '0;
         hold_q[0]  <= '0;
         hold_q[1]  <= '0;
         started_q  <= 1'b0;
         pending_q  <= 1'b0;
         wr_err_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         shadow_q    <= shadow_d;
         data_q      <= data_d;
         hold_data_q <= hold_data_d;
         valid_q     <= valid_d;
         hold_q      <= hold_d;
         started_q   <= 1'b1;
         pending_q   <= pending_d;
         wr_err_q    <= wr_err_d;
         cnt_q       <= cnt_d;
      end
   end

   for (genvar c = 0; c < int'(CH_NUM); c++) begin : g_out
      assign m_axis.gain_m_axis_tdata[c*DW +: DW]   = data_q[0][c];
      assign m_axis.offset_m_axis_tdata[c*DW +: DW] = data_q[1][c];
   end

   assign m_axis.gain_m_axis_tvalid   = valid_q[0];
   assign m_axis.offset_m_axis_tvalid = valid_q[1];

   assign o_pending   = pending_q;
   assign o_wr_err    = wr_err_q;
   assign o_apply_cnt = cnt_q;

endmodule

// File: tb/tb_adc_calc_val_bank.sv
// Bench for adc_calc_val_bank: a MODE 0 and a MODE 1 instance share the control
// inputs and are compared each cycle against a beat-level reference model.
module tb_adc_calc_val_bank;

   localparam int unsigned CH = 3;
   localparam int unsigned DW = 32;
   localparam logic [31:0] DG = 32'h35A0_0000;
   localparam logic [31:0] DO = 32'hC120_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [3:0]  ch;
   logic        sel;
   logic [31:0] wd;
   logic        apply;
   logic        restore;
   logic [2:0]  rdy0_g, rdy0_o, rdy1_g, rdy1_o;
   logic        pend0, err0, pend1, err1;
   logic [15:0] cnt0, cnt1;

   adc_calc_val_bank_if #(.CH_NUM(CH), .DW(DW)) if0 ();
   adc_calc_val_bank_if #(.CH_NUM(CH), .DW(DW)) if1 ();

   assign if0.gain_m_axis_tready   = rdy0_g;
   assign if0.offset_m_axis_tready = rdy0_o;
   assign if1.gain_m_axis_tready   = rdy1_g;
   assign if1.offset_m_axis_tready = rdy1_o;

   adc_calc_val_bank #(
      .CH_NUM(CH), .DW(DW), .DEF_GAIN(DG), .DEF_OFFSET(DO), .MODE(0)
   ) u_dut0 (
      .i_clk(clk), .i_rst(rst_n), .i_wr_en(we), .i_wr_ch(ch), .i_wr_sel(sel),
      .i_wr_data(wd), .i_apply(apply), .i_restore(restore), .m_axis(if0.master),
      .o_pending(pend0), .o_wr_err(err0), .o_apply_cnt(cnt0)
   );

   adc_calc_val_bank #(
      .CH_NUM(CH), .DW(DW), .DEF_GAIN(DG), .DEF_OFFSET(DO), .MODE(1)
   ) u_dut1 (
      .i_clk(clk), .i_rst(rst_n), .i_wr_en(we), .i_wr_ch(ch), .i_wr_sel(sel),
      .i_wr_data(wd), .i_apply(apply), .i_restore(restore), .m_axis(if1.master),
      .o_pending(pend1), .o_wr_err(err1), .o_apply_cnt(cnt1)
   );

   always #5 clk = ~clk;

   // Reference model: shadow values, MODE 0 active values, MODE 1 presented beat
   // plus a one-deep "next beat" slot (latest commit wins).
   logic [31:0] m_sh  [2][CH];
   logic [31:0] m_d0  [2][CH];
   logic [31:0] m_d1  [2][CH];
   logic [31:0] m_nxt [2][CH];
   logic        m_v1  [2][CH];
   logic        m_has [2][CH];
   logic        m_v0;
   logic        m_pend, m_err;
   logic [15:0] m_cnt;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] def_of(input int s);
      return (s == 0) ? DG : DO;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int c = 0; c < int'(CH); c++) begin
            m_sh[s][c]  = def_of(s);
            m_d0[s][c]  = def_of(s);
            m_d1[s][c]  = def_of(s);
            m_nxt[s][c] = def_of(s);
            m_has[s][c] = 1'b1;   // defaults are the first beat after reset
            m_v1[s][c]  = 1'b0;
         end
      end
      m_v0   = 1'b0;
      m_pend = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 16'd0;
   endtask

   task automatic model_edge();
      logic        commit, wr_ok, oob, busy;
      logic [31:0] cval;
      logic [2:0]  r1;
      commit = apply | restore;
      oob    = we && (int'(ch) >= int'(CH));
      wr_ok  = we && !oob && !restore;
      for (int s = 0; s < 2; s++) begin
         r1 = (s == 0) ? rdy1_g : rdy1_o;
         for (int c = 0; c < int'(CH); c++) begin
            if (restore) cval = def_of(s);
            else if (wr_ok && int'(ch) == c && int'(sel) == s) cval = wd;
            else cval = m_sh[s][c];
            m_sh[s][c] = cval;
            if (commit) m_d0[s][c] = cval;
            busy = m_v1[s][c] && !r1[c];
            if (commit) begin
               m_nxt[s][c] = cval;
               m_has[s][c] = 1'b1;
            end
            if (!busy) begin
               m_v1[s][c] = m_has[s][c];
               if (m_has[s][c]) m_d1[s][c] = m_nxt[s][c];
               m_has[s][c] = 1'b0;
            end
         end
      end
      m_v0 = 1'b1;
      if (commit) m_pend = 1'b0;
      else if (wr_ok) m_pend = 1'b1;
      if (restore) m_err = 1'b0;
      else if (oob) m_err = 1'b1;
      else if (apply) m_err = 1'b0;
      if (apply && !restore) m_cnt = m_cnt + 16'd1;
   endtask

   task automatic compare_all();
      logic [95:0] eg0, eo0, eg1, eo1;
      logic [2:0]  vg1, vo1;
      for (int c = 0; c < int'(CH); c++) begin
         eg0[c*32 +: 32] = m_d0[0][c];
         eo0[c*32 +: 32] = m_d0[1][c];
         eg1[c*32 +: 32] = m_d1[0][c];
         eo1[c*32 +: 32] = m_d1[1][c];
         vg1[c]          = m_v1[0][c];
         vo1[c]          = m_v1[1][c];
      end
      check("m0_gain_data",  128'(if0.gain_m_axis_tdata),    128'(eg0));
      check("m0_off_data",   128'(if0.offset_m_axis_tdata),  128'(eo0));
      check("m0_gain_valid", 128'(if0.gain_m_axis_tvalid),   128'({3{m_v0}}));
      check("m0_off_valid",  128'(if0.offset_m_axis_tvalid), 128'({3{m_v0}}));
      check("m1_gain_data",  128'(if1.gain_m_axis_tdata),    128'(eg1));
      check("m1_off_data",   128'(if1.offset_m_axis_tdata),  128'(eo1));
      check("m1_gain_valid", 128'(if1.gain_m_axis_tvalid),   128'(vg1));
      check("m1_off_valid",  128'(if1.offset_m_axis_tvalid), 128'(vo1));
      check("pending", 128'({pend0, pend1}), 128'({m_pend, m_pend}));
      check("wr_err",  128'({err0, err1}),   128'({m_err, m_err}));
      check("cnt0",    128'(cnt0), 128'(m_cnt));
      check("cnt1",    128'(cnt1), 128'(m_cnt));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle();
      we      = 1'b0;
      apply   = 1'b0;
      restore = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      ch = '0; sel = 1'b0; wd = '0;
      rdy0_g = '0; rdy0_o = '0;
      rdy1_g = 3'b110;  // ch0 gain of the MODE 1 instance stalls for the hold test
      rdy1_o = 3'b111;
      model_reset();
      #12;
      compare_all();
      check("rst_valid", 128'({if0.gain_m_axis_tvalid, if1.gain_m_axis_tvalid}), 128'(0));

      @(posedge clk); #1;
      rst_n = 1'b1;
      step();
      check("first_valid", 128'({if0.gain_m_axis_tvalid, if0.offset_m_axis_tvalid,
                                  if1.gain_m_axis_tvalid, if1.offset_m_axis_tvalid}),
            128'(12'hFFF));
      check("first_gain", 128'(if0.gain_m_axis_tdata), 128'({3{DG}}));
      check("first_off",  128'(if1.offset_m_axis_tdata), 128'({3{DO}}));

      // Shadow write then apply.
      we = 1'b1; ch = 4'd1; sel = 1'b0; wd = 32'h39A0_00A0;
      step();
      check("pend_after_wr", 128'(pend0), 128'(1));
      idle(); apply = 1'b1;
      step();
      idle();
      check("ch1_gain",  128'(if0.gain_m_axis_tdata), 128'({DG, 32'h39A0_00A0, DG}));
      check("apply_cnt", 128'(cnt0), 128'(1));
      check("pend_clr",  128'(pend0), 128'(0));

      // Out-of-range channel write.
      we = 1'b1; ch = 4'd5; wd = 32'hDEAD_BEEF;
      step();
      check("wr_err_set", 128'(err0), 128'(1));
      idle(); apply = 1'b1;
      step();
      idle();
      check("wr_err_clr", 128'(err0), 128'(0));

      // Restore beats simultaneous write and apply.
      we = 1'b1; ch = 4'd0; sel = 1'b1; wd = 32'h3F80_0000; apply = 1'b1; restore = 1'b1;
      step();
      idle();
      check("restore_off",  128'(if0.offset_m_axis_tdata), 128'({3{DO}}));
      check("restore_gain", 128'(if0.gain_m_axis_tdata),   128'({3{DG}}));
      check("restore_cnt",  128'(cnt0), 128'(2));

      // MODE 1: two commits while ch0 gain stalls; only the latest is delivered.
      we = 1'b1; ch = 4'd0; sel = 1'b0; wd = 32'h1111_1111; apply = 1'b1;
      step();
      check("m1_stall_a", 128'(if1.gain_m_axis_tdata[31:0]), 128'(DG));
      wd = 32'h2222_2222;
      step();
      idle();
      check("m1_stall_b", 128'(if1.gain_m_axis_tdata[31:0]), 128'(DG));
      rdy1_g = 3'b111;
      step();
      check("m1_beat2_data",  128'(if1.gain_m_axis_tdata[31:0]), 128'(32'h2222_2222));
      check("m1_beat2_valid", 128'(if1.gain_m_axis_tvalid[0]), 128'(1));
      step();
      check("m1_drained", 128'(if1.gain_m_axis_tvalid[0]), 128'(0));

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         we      = ($urandom_range(0, 1) == 1);
         sel     = 1'($urandom_range(0, 1));
         wd      = $urandom;
         ch      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15))
                                               : 4'($urandom_range(0, 2));
         apply   = ($urandom_range(0, 3) == 0);
         restore = ($urandom_range(0, 15) == 0);
         if (we && ch >= 4'd3) apply = 1'b0;
         rdy0_g  = 3'($urandom); rdy0_o = 3'($urandom);
         rdy1_g  = 3'($urandom); rdy1_o = 3'($urandom);
         step();
      end
      idle();

      // Counter wrap from a fresh reset.
      rst_n = 1'b0;
      model_reset();
      #1;
      check("wrap_rst_cnt", 128'(cnt0), 128'(0));
      rst_n = 1'b1;
      apply = 1'b1;
      for (int i = 0; i < 65535; i++) step();
      check("cnt_ffff", 128'(cnt0), 128'(16'hFFFF));
      step();
      check("cnt_wrap", 128'({cnt0, cnt1}), 128'(32'h0));
      for (int i = 0; i < 5; i++) step();

      // Asynchronous reset mid-sequence.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_cnt",   128'({cnt0, cnt1}), 128'(0));
      check("async_valid", 128'({if0.gain_m_axis_tvalid, if0.offset_m_axis_tvalid,
                                  if1.gain_m_axis_tvalid, if1.offset_m_axis_tvalid}),
            128'(0));
      idle();
      model_reset();
      compare_all();
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
